// File: rtl/vproc_div_iter_pkg.sv
// Shared constants for the iterative divider core of the vector divide unit.
// Parameter defaults live here so the core and its users agree on them.
package vproc_div_iter_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;
    localparam int unsigned DIV_TAG_W_DEFAULT = 4;

endpackage

// File: rtl/vproc_div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, with RISC-V
// DIV/DIVU/REM/REMU semantics and valid/ready handshakes on both sides.
module vproc_div_iter
    import vproc_div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT,
    parameter int unsigned TAG_W = DIV_TAG_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             pipe_in_valid_i,
    output logic             pipe_in_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             signed_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             pipe_out_valid_o,
    input  logic             pipe_out_ready_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     r_q;
    logic [WIDTH-1:0]   q_q, b_q, quot_q, rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q_q, neg_r_q;
    logic [TAG_W-1:0]   tag_q;

    logic               accept, a_neg, b_neg, div_zero, overflow, last;
    logic [WIDTH-1:0]   abs_a, abs_b, step_q;
    logic [WIDTH:0]     shift_r, diff, step_r;

    assign pipe_in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & pipe_out_ready_i);
    assign pipe_out_valid_o = (state_q == DONE);
    assign accept           = pipe_in_valid_i & pipe_in_ready_o;

    assign a_neg    = signed_i & op_a_i[WIDTH-1];
    assign b_neg    = signed_i & op_b_i[WIDTH-1];
    assign abs_a    = a_neg ? -op_a_i : op_a_i;
    assign abs_b    = b_neg ? -op_b_i : op_b_i;
    assign div_zero = (op_b_i == '0);
    assign overflow = signed_i & (op_a_i == MIN_NEG) & (op_b_i == '1);

    // One restoring step: trial-subtract the divisor from the shifted remainder.
    assign shift_r = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign diff    = shift_r - {1'b0, b_q};
    assign step_r  = diff[WIDTH] ? shift_r : diff;
    assign step_q  = {q_q[WIDTH-2:0], ~diff[WIDTH]};
    assign last    = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept)
                    state_d = (div_zero | overflow) ? DONE : BUSY;
                else if ((state_q == DONE) && pipe_out_ready_i)
                    state_d = IDLE;
            end
            BUSY: if (last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            tag_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q   <= tag_i;
                neg_q_q <= a_neg ^ b_neg;
                neg_r_q <= a_neg;
                q_q     <= abs_a;
                b_q     <= abs_b;
                r_q     <= '0;
                cnt_q   <= CNT_W'(WIDTH - 1);
                if (div_zero) begin
                    quot_q <= '1;
                    rem_q  <= op_a_i;
                end else if (overflow) begin
                    quot_q <= op_a_i;
                    rem_q  <= '0;
                end
            end else if (state_q == BUSY) begin
                r_q   <= step_r;
                q_q   <= step_q;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last) begin
                    quot_q <= neg_q_q ? -step_q : step_q;
                    rem_q  <= neg_r_q ? -step_r[WIDTH-1:0] : step_r[WIDTH-1:0];
                end
            end
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign tag_o  = tag_q;

endmodule

// File: tb/tb_vproc_div_iter.sv
// Directed bench for vproc_div_iter: results, latency, backpressure,
// back-to-back handshakes and asynchronous reset mid-operation.
module tb_vproc_div_iter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;

    logic             clk_i = 1'b0;
    logic             async_rst_ni = 1'b0;
    logic             pipe_in_valid_i = 1'b0;
    logic             pipe_in_ready_o;
    logic [WIDTH-1:0] op_a_i = '0;
    logic [WIDTH-1:0] op_b_i = '0;
    logic             signed_i = 1'b0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             pipe_out_valid_o;
    logic             pipe_out_ready_i = 1'b0;
    logic [WIDTH-1:0] quot_o;
    logic [WIDTH-1:0] rem_o;
    logic [TAG_W-1:0] tag_o;

    int vectors = 0;
    int miscompares = 0;

    vproc_div_iter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk_i            (clk_i),
        .async_rst_ni     (async_rst_ni),
        .pipe_in_valid_i  (pipe_in_valid_i),
        .pipe_in_ready_o  (pipe_in_ready_o),
        .op_a_i           (op_a_i),
        .op_b_i           (op_b_i),
        .signed_i         (signed_i),
        .tag_i            (tag_i),
        .pipe_out_valid_o (pipe_out_valid_o),
        .pipe_out_ready_i (pipe_out_ready_i),
        .quot_o           (quot_o),
        .rem_o            (rem_o),
        .tag_o            (tag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Present operands, hold valid until the handshake edge, sample #1 after it.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [TAG_W-1:0] t);
        int n = 0;
        op_a_i = a;
        op_b_i = b;
        signed_i = s;
        tag_i = t;
        pipe_in_valid_i = 1'b1;
        #1;
        while (!pipe_in_ready_o && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        @(posedge clk_i);
        #1;
        pipe_in_valid_i = 1'b0;
    endtask

    // Edges counted from the accept edge (inclusive) until valid is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!pipe_out_valid_o && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        pipe_out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        pipe_out_ready_i = 1'b0;
    endtask

    initial begin
        int lat;
        logic seen;

        #12;
        check("rst_in_ready", pipe_in_ready_o, 1);
        check("rst_out_valid", pipe_out_valid_o, 0);
        check("rst_quot", quot_o, 0);
        check("rst_rem", rem_o, 0);
        check("rst_tag", tag_o, 0);
        @(posedge clk_i);
        #1;
        async_rst_ni = 1'b1;

        // Unsigned 100 / 7
        send(32'd100, 32'd7, 1'b0, 4'd3);
        wait_result(lat);
        check("udiv_latency", lat, 33);
        check("udiv_quot", quot_o, 14);
        check("udiv_rem", rem_o, 2);
        check("udiv_tag", tag_o, 3);
        pop();
        check("udiv_popped", pipe_out_valid_o, 0);

        // Signed -7 / 2
        send(32'hFFFF_FFF9, 32'd2, 1'b1, 4'd5);
        wait_result(lat);
        check("sdiv_latency", lat, 33);
        check("sdiv_quot", quot_o, 32'hFFFF_FFFD);
        check("sdiv_rem", rem_o, 32'hFFFF_FFFF);
        check("sdiv_tag", tag_o, 5);
        pop();

        // Signed 7 / -2
        send(32'd7, 32'hFFFF_FFFE, 1'b1, 4'd6);
        wait_result(lat);
        check("sdiv_nb_quot", quot_o, 32'hFFFF_FFFD);
        check("sdiv_nb_rem", rem_o, 1);
        pop();

        // Division by zero, unsigned and signed
        send(32'h1234, 32'd0, 1'b0, 4'd7);
        wait_result(lat);
        check("dz_u_latency", lat, 1);
        check("dz_u_quot", quot_o, 32'hFFFF_FFFF);
        check("dz_u_rem", rem_o, 32'h1234);
        check("dz_u_tag", tag_o, 7);
        pop();
        send(32'h1234, 32'd0, 1'b1, 4'd8);
        wait_result(lat);
        check("dz_s_latency", lat, 1);
        check("dz_s_quot", quot_o, 32'hFFFF_FFFF);
        check("dz_s_rem", rem_o, 32'h1234);
        pop();

        // Signed overflow
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd2);
        wait_result(lat);
        check("ovf_latency", lat, 1);
        check("ovf_quot", quot_o, 32'h8000_0000);
        check("ovf_rem", rem_o, 0);
        pop();

        // Backpressure: hold the result for 5 cycles
        send(32'd50, 32'd5, 1'b0, 4'd1);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", pipe_out_valid_o, 1);
            check("bp_in_ready", pipe_in_ready_o, 0);
            check("bp_quot", quot_o, 10);
            check("bp_rem", rem_o, 0);
            check("bp_tag", tag_o, 1);
            @(posedge clk_i);
            #1;
        end

        // Simultaneous output and input handshake
        op_a_i = 32'hFFFF_FFFF;
        op_b_i = 32'h10;
        signed_i = 1'b0;
        tag_i = 4'd9;
        pipe_in_valid_i = 1'b1;
        pipe_out_ready_i = 1'b1;
        #1;
        check("b2b_in_ready", pipe_in_ready_o, 1);
        @(posedge clk_i);
        #1;
        pipe_in_valid_i = 1'b0;
        pipe_out_ready_i = 1'b0;
        check("b2b_busy", pipe_out_valid_o, 0);
        wait_result(lat);
        check("b2b_latency", lat, 33);
        check("b2b_quot", quot_o, 32'h0FFF_FFFF);
        check("b2b_rem", rem_o, 32'hF);
        check("b2b_tag", tag_o, 9);
        pop();

        // Reset at BUSY cycle 10
        send(32'd1000, 32'd3, 1'b0, 4'd4);
        repeat (9) begin
            @(posedge clk_i);
            #1;
        end
        async_rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", pipe_out_valid_o, 0);
        check("mid_rst_in_ready", pipe_in_ready_o, 1);
        check("mid_rst_quot", quot_o, 0);
        @(posedge clk_i);
        #1;
        async_rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            seen = seen | pipe_out_valid_o;
        end
        check("no_stale_result", seen, 0);

        // Recovery after reset
        send(32'd9, 32'd3, 1'b0, 4'd10);
        wait_result(lat);
        check("post_rst_latency", lat, 33);
        check("post_rst_quot", quot_o, 3);
        check("post_rst_rem", rem_o, 0);
        check("post_rst_tag", tag_o, 10);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vproc_div_iter.md
# vproc_div_iter

Iterative radix-2 restoring divider core for the vector divide unit. It sits between the divide-input and divide-output buffer stages of `vproc_div`. It consumes one operand pair per handshake and returns the quotient and remainder under a valid/ready handshake. It implements RISC-V DIV/DIVU/REM/REMU semantics, including division by zero and signed overflow.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width in bits, must be ≥ 2.
- `TAG_W`, default 4: width of the opaque tag that passes through with each operation.

Ports:
- `clk_i`, input, 1: clock.
- `async_rst_ni`, input, 1: reset. Asynchronous, active-low.
- `pipe_in_valid_i`, input, 1: operand pair valid.
- `pipe_in_ready_o`, output, 1: core can accept an operand pair.
- `op_a_i`, input, WIDTH: dividend.
- `op_b_i`, input, WIDTH: divisor.
- `signed_i`, input, 1: 1 = signed operation, 0 = unsigned.
- `tag_i`, input, TAG_W: passthrough tag.
- `pipe_out_valid_o`, output, 1: result valid.
- `pipe_out_ready_i`, input, 1: downstream accepts the result.
- `quot_o`, output, WIDTH: quotient.
- `rem_o`, output, WIDTH: remainder.
- `tag_o`, output, TAG_W: tag of the current result.

## Operation

State machine states: IDLE, BUSY, DONE. Reset state is IDLE.

- **Input handshake:** occurs when `pipe_in_valid_i` and `pipe_in_ready_o` are both high at a rising edge.
- **`pipe_in_ready_o`:** equals `(state==IDLE) | (state==DONE & pipe_out_ready_i)`. This is a combinational path from `pipe_out_ready_i`; it is intentional.
- **On accept:**
  - Latch `tag_i` and `signed_i`.
  - Latch the absolute values |a| and |b| when signed, or the raw values when unsigned.
  - Latch `neg_q = signed & (a[MSB] ^ b[MSB])` and `neg_r = signed & a[MSB]`.
- **Special cases on accept (go directly to DONE):**
  - `op_b_i == 0`: quot = all ones, rem = `op_a_i`.
  - Signed, `op_a_i == 1<<(WIDTH-1)` and `op_b_i == all ones`: quot = `op_a_i`, rem = 0.
- **Normal case on accept:** go to BUSY. Clear the partial remainder `R` (WIDTH+1 bits). Load `Q` = |a|. Load the counter = WIDTH-1.
- **BUSY step, once per cycle:**
  - `T = {R[WIDTH-1:0], Q[MSB]} - {1'b0, |b|}`.
  - If `T` is non-negative: `R = T` and shift 1 into `Q`.
  - Otherwise: `R = {R[WIDTH-1:0], Q[MSB]}` and shift 0 into `Q`.
  - Decrement the counter.
- **Leaving BUSY:** the step taken when the counter reaches 0 is the last one, and the core goes to DONE. On this transition, register `quot = neg_q ? -Q : Q` and `rem = neg_r ? -R : R`.
- **DONE:**
  - `pipe_out_valid_o` = 1. `quot_o`, `rem_o` and `tag_o` are held stable until the output handshake.
  - Output handshake without a simultaneous input handshake: go to IDLE.
  - Output and input handshake in the same cycle: start the new operation with the same rules as from IDLE.
- **Reset mid-operation:** `async_rst_ni` low forces IDLE immediately. The in-flight operation is discarded and no result is emitted.
- **Reset values of outputs:**
  - `pipe_in_ready_o` = 1.
  - `pipe_out_valid_o` = 0.
  - `quot_o`, `rem_o` and `tag_o` are 0.
- **Input changes outside a handshake:** ignored.

## Timing

- **Normal latency:** the input handshake at edge E0 is followed by WIDTH BUSY cycles. `pipe_out_valid_o` rises after edge E0+WIDTH, which is WIDTH+1 cycles after the accept cycle (33 cycles for WIDTH=32).
- **Special-case latency:** `pipe_out_valid_o` is high in the cycle right after the accept cycle.
- **Throughput:** one operation per WIDTH+1 cycles with back-to-back accept in DONE, or WIDTH+2 cycles if the core returns to IDLE first.
- **No combinational paths from operand inputs to outputs.** The only combinational path is `pipe_out_ready_i` to `pipe_in_ready_o`.

## Structure

- Single module; no sub-module.
- No new typedefs are needed in `vproc_pkg`.
- The state enum is local to the module.
- Negation and absolute value use WIDTH-bit two's complement with wrap-around.

## Test plan

- **Unsigned division:** unsigned 100 / 7 -> quot = 14, rem = 2; `pipe_out_valid_o` rises exactly 33 cycles after the accept cycle; `tag_o` equals `tag_i`.
- **Signed division with negative dividend:** signed 0xFFFFFFF9 (-7) / 2 -> quot = 0xFFFFFFFD, rem = 0xFFFFFFFF.
- **Division by zero:** 0x1234 / 0, both signed and unsigned -> quot = 0xFFFFFFFF, rem = 0x1234, valid one cycle after accept.
- **Signed overflow:** signed 0x80000000 / 0xFFFFFFFF -> quot = 0x80000000, rem = 0, latency 1.
- **Backpressure and back-to-back:**
  - Hold `pipe_out_ready_i` low for 5 cycles in DONE -> outputs stable and `pipe_in_ready_o` = 0.
  - Raise `pipe_out_ready_i` with a new input valid -> both handshakes occur in the same cycle, and the next result (unsigned 0xFFFFFFFF / 0x10 -> quot = 0x0FFFFFFF, rem = 0xF) arrives 33 cycles later.
- **Reset mid-operation:** assert `async_rst_ni` low at BUSY cycle 10 -> immediately `pipe_out_valid_o` = 0 and `pipe_in_ready_o` = 1; no stale result is emitted after reset is released.
